// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small
// instruction queue toward decode, with redirect flush and response drop.
module ysyx_22041207_ifu #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [31:0]     q_inst [QDEPTH];

    logic            accept;
    logic            enq;
    logic            deq;
    logic [XLEN-1:0] redirect_aligned;

    // Issue only with a free queue slot, so a response always has room
    assign imem_req_valid   = (state == REQ) && (count < CW'(QDEPTH));
    assign imem_req_addr    = fetch_pc;
    assign id_valid         = (count != '0);
    assign id_inst          = q_inst[rd_ptr];
    assign id_pc            = q_pc[rd_ptr];

    assign accept           = imem_req_valid && imem_req_ready;
    assign enq              = (state == WAIT) && imem_resp_valid;
    assign deq              = id_valid && id_ready;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Fetch FSM, PC tracking and instruction queue; redirect overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            case (state)
                IDLE:    state <= REQ;
                REQ:     state <= accept ? DROP : REQ;
                WAIT:    state <= DROP;
                default: state <= DROP;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (accept) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: begin
                    if (imem_resp_valid) begin
                        state <= REQ;
                    end
                end
            endcase

            if (enq) begin
                q_pc[wr_ptr]   <= req_pc;
                q_inst[wr_ptr] <= imem_resp_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Directed self-checking bench for the instruction fetch unit.
module tb_ysyx_22041207_ifu;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;

    int checks;
    int failures;

    ysyx_22041207_ifu #(
        .XLEN    (64),
        .RESET_PC(64'h8000_0000),
        .QDEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a request at the expected address, then respond the next cycle
    task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] data);
        chk({tag, "_reqv"}, 64'(imem_req_valid), 64'd1);
        chk({tag, "_addr"}, imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        chk({tag, "_wait"}, 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_reqv",  64'(imem_req_valid), 64'd0);
        chk("rst_idv",   64'(id_valid),       64'd0);
        chk("rst_inst",  64'(id_inst),        64'd0);
        chk("rst_idpc",  id_pc,               64'd0);
        chk("rst_addr",  imem_req_addr,       64'h8000_0000);
        rst_n = 1'b1;

        // First edge after release: IDLE -> REQ, no request yet
        chk("idle_reqv", 64'(imem_req_valid), 64'd0);
        step();
        id_ready = 1'b1;

        // Streaming fetch with decode always ready
        fetch("s0", 64'h8000_0000, 32'h0000_0013);
        chk("s0_idv",  64'(id_valid), 64'd1);
        chk("s0_pc",   id_pc,         64'h8000_0000);
        chk("s0_inst", 64'(id_inst),  64'h0000_0013);
        fetch("s1", 64'h8000_0004, 32'h0010_0093);
        chk("s1_pc",   id_pc,         64'h8000_0004);
        chk("s1_inst", 64'(id_inst),  64'h0010_0093);
        fetch("s2", 64'h8000_0008, 32'h0020_0113);
        chk("s2_pc",   id_pc,         64'h8000_0008);
        chk("s2_inst", 64'(id_inst),  64'h0020_0113);

        // Drain, then fill the queue with decode stalled
        imem_req_ready = 1'b0;
        step();
        chk("drain_idv", 64'(id_valid), 64'd0);
        id_ready = 1'b0;
        fetch("f0", 64'h8000_000c, 32'hA000_0000);
        fetch("f1", 64'h8000_0010, 32'hA000_0001);
        fetch("f2", 64'h8000_0014, 32'hA000_0002);
        fetch("f3", 64'h8000_0018, 32'hA000_0003);
        chk("full_reqv", 64'(imem_req_valid), 64'd0);
        chk("full_head", id_pc,               64'h8000_000c);
        step();
        step();
        chk("full_hold", 64'(imem_req_valid), 64'd0);

        // One dequeue frees a slot for exactly one more request
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        fetch("f4", 64'h8000_001c, 32'hA000_0004);
        chk("refull_reqv", 64'(imem_req_valid), 64'd0);
        step();
        chk("refull_hold", 64'(imem_req_valid), 64'd0);

        // Drain in FIFO order across the pointer wrap
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        chk("d0_pc",   id_pc,        64'h8000_0010);
        chk("d0_inst", 64'(id_inst), 64'hA000_0001);
        step();
        chk("d1_pc",   id_pc,        64'h8000_0014);
        step();
        chk("d2_pc",   id_pc,        64'h8000_0018);
        step();
        chk("d3_pc",   id_pc,        64'h8000_001c);
        chk("d3_inst", 64'(id_inst), 64'hA000_0004);
        step();
        chk("d4_idv",  64'(id_valid), 64'd0);

        // Redirect while request is not accepted: address moves, stays in REQ
        chk("rr_addr0", imem_req_addr, 64'h8000_0020);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2006;
        step();
        redirect_valid = 1'b0;
        chk("rr_reqv", 64'(imem_req_valid), 64'd1);
        chk("rr_addr", imem_req_addr,       64'h8000_2004);
        fetch("rr", 64'h8000_2004, 32'hB000_0000);
        chk("rr_pc", id_pc, 64'h8000_2004);

        // Redirect while waiting: pending response dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1003;
        step();
        redirect_valid = 1'b0;
        chk("rw_idv",  64'(id_valid),       64'd0);
        chk("rw_reqv", 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("rw_drop", 64'(id_valid),  64'd0);
        chk("rw_addr", imem_req_addr,  64'h8000_1000);
        fetch("rw", 64'h8000_1000, 32'hC000_0000);
        chk("rw_pc",   id_pc,          64'h8000_1000);
        chk("rw_inst", 64'(id_inst),   64'hC000_0000);

        // Redirect in the same cycle as accept: that response dropped
        chk("ra_addr0", imem_req_addr, 64'h8000_1004);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        chk("ra_reqv", 64'(imem_req_valid), 64'd0);
        chk("ra_flush", 64'(id_valid),      64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0001;
        step();
        imem_resp_valid = 1'b0;
        chk("ra_drop", 64'(id_valid), 64'd0);
        fetch("ra", 64'h8000_3000, 32'hD000_0000);
        chk("ra_pc",   id_pc,        64'h8000_3000);
        chk("ra_inst", 64'(id_inst), 64'hD000_0000);

        // Reset while waiting, then a stale response after release
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_reqv", 64'(imem_req_valid), 64'd0);
        chk("mr_idv",  64'(id_valid),       64'd0);
        chk("mr_addr", imem_req_addr,       64'h8000_0000);
        step();
        rst_n           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0002;
        step();
        imem_resp_valid = 1'b0;
        chk("mr_stale", 64'(id_valid), 64'd0);
        step();
        chk("mr_stale2", 64'(id_valid), 64'd0);
        fetch("mr", 64'h8000_0000, 32'hE000_0000);
        chk("mr_pc", id_pc, 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
